alu_muldiv: RTL and testbench



---
 rtl/alu_muldiv_if.sv | 23 ++
 rtl/alu_muldiv.sv | 138 +++++++++++++
 tb/tb_alu_muldiv.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic [2:0]       i_muldiv_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             i_flush;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_valid, i_muldiv_op, i_operand_a, i_operand_b, i_flush,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_muldiv_op, i_operand_a, i_operand_b, i_flush,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Define MULDIV_EARLY_OUT_EN to let trivial operations bypass the iteration phase.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    alu_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [2:0]           op;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic                 valid_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept, early;
    logic                 a_signed, b_signed, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]     in_mag_a, in_mag_b;
    logic [2*WIDTH-1:0]   acc_init, acc_step, prod_full;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]     quot, rem, result;

    assign bus.o_ready  = (state == IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

    always_comb begin
        accept   = bus.i_valid && (state == IDLE) && !bus.i_flush;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.i_muldiv_op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        in_neg_a = a_signed & bus.i_operand_a[WIDTH-1];
        in_neg_b = b_signed & bus.i_operand_b[WIDTH-1];
        in_mag_a = in_neg_a ? -bus.i_operand_a : bus.i_operand_a;
        in_mag_b = in_neg_b ? -bus.i_operand_b : bus.i_operand_b;
        // Divide keeps {remainder, quotient} in acc; multiply keeps the product with the multiplier in the low half.
        acc_init = bus.i_muldiv_op[2] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
        early    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        if (bus.i_muldiv_op[2]) begin
            if (bus.i_operand_b == '0) begin
                early    = 1'b1;
                acc_init = {in_mag_a, {WIDTH{1'b1}}};
            end else if (a_signed && (bus.i_operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.i_operand_b == '1)) begin
                early    = 1'b1;
            end
        end else if ((bus.i_operand_a == '0) || (bus.i_operand_b == '0)) begin
            early    = 1'b1;
            acc_init = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = early ? DONE : BUSY;
            BUSY: begin
                if (bus.i_flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mag_b};
        if (op[2])
            acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        prod_full = (neg_a ^ neg_b) ? -acc : acc;
        quot      = acc[WIDTH-1:0];
        rem       = acc[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 result = prod_full[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result = prod_full[2*WIDTH-1:WIDTH];
            // A zero divisor leaves the all-ones quotient uncorrected.
            3'b100, 3'b101:         result = ((neg_a ^ neg_b) && (mag_b != '0)) ? -quot : quot;
            default:                result = neg_a ? -rem : rem;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            acc      <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= (state == DONE) && !bus.i_flush;
            if ((state == DONE) && !bus.i_flush)
                result_q <= result;
            if (accept) begin
                op    <= bus.i_muldiv_op;
                neg_a <= in_neg_a;
                neg_b <= in_neg_b;
                mag_a <= in_mag_a;
                mag_b <= in_mag_b;
                cnt   <= '0;
                acc   <= acc_init;
            end else if ((state == BUSY) && !bus.i_flush) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed RV32M vectors, flush, reset and latency checks.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_alu_muldiv;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic [W-1:0] last_res;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        int           lat;
        int           acc_cyc;
    } exp_t;
    exp_t sb[$];

    alu_muldiv_if #(.WIDTH(W)) bus ();
    alu_muldiv #(.WIDTH(W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic special;
        if (op[2])
            special = (b == 0) || ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            special = (a == 0) || (b == 0);
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 1 : W + 1;
`else
        return (special === 1'bx) ? 0 : W + 1;
`endif
    endfunction

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got o_valid=1 result %h expected no completion", bus.o_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, bus.o_result, e.res);
                chk({e.name, "_latency"}, W'(cyc - e.acc_cyc), W'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_ready !== 1'b1) chk({name, "_ready_timeout"}, bus.o_ready, 1);
        bus.i_valid     = 1'b1;
        bus.i_muldiv_op = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
        bus.i_muldiv_op = 3'($urandom);
        bus.i_operand_a = $urandom;
        bus.i_operand_b = $urandom;
        if (push) begin
            e.name    = name;
            e.res     = exp;
            e.lat     = model_lat(op, a, b);
            e.acc_cyc = cyc;
            sb.push_back(e);
            last_res  = exp;
        end
    endtask

    // Counts cycles with o_ready low until the unit returns to idle.
    task automatic wait_idle(input string name, input int exp_low);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_ready_low_cycles"}, W'(n), W'(exp_low));
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
        issue(name, op, a, b, exp, 1'b1);
        wait_idle(name, model_lat(op, a, b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_res = '0;
        bus.i_valid = 1'b0;
        bus.i_muldiv_op = '0;
        bus.i_operand_a = '0;
        bus.i_operand_b = '0;
        bus.i_flush = 1'b0;
        rst = 1'b1;
        #23;
        chk("reset_ready", bus.o_ready, 1);
        chk("reset_valid", bus.o_valid, 0);
        chk("reset_result", bus.o_result, 0);
        @(negedge clk);
        rst = 1'b0;

        run("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulh_min_min",  3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run("mulhu_min_min", 3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulh_m1_2",     3'b001, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run("mul_zero_a",    3'b000, 32'd0,          32'd12345,     32'd0);
        run("div_m20_3",     3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA);
        run("rem_m20_3",     3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE);
        run("divu_20_3",     3'b101, 32'd20,         32'd3,         32'd6);
        run("remu_20_3",     3'b111, 32'd20,         32'd3,         32'd2);
        run("div_7_m3",      3'b100, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFE);
        run("rem_7_m3",      3'b110, 32'd7,          32'hFFFF_FFFD, 32'd1);
        run("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run("divu_by0",      3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run("remu_by0",      3'b111, 32'd5,          32'd0,         32'd5);
        run("div_m20_by0",   3'b100, 32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFFF);
        run("rem_m20_by0",   3'b110, 32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC);

        // Flush in idle blocks the accept.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_muldiv_op = 3'b101;
        bus.i_operand_a = 32'd9;
        bus.i_operand_b = 32'd2;
        @(posedge clk);
        #1;
        chk("idle_flush_blocks_accept", bus.o_ready, 1);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;

        // Flush mid-divide, then an immediate follow-up op with ignored i_valid pulses.
        issue("div_flushed", 3'b100, 32'd1000, 32'd7, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        chk("flush_ready", bus.o_ready, 1);
        chk("flush_valid", bus.o_valid, 0);
        chk("flush_result_held", bus.o_result, last_res);
        issue("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        repeat (5) @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_muldiv_op = 3'b000;
        bus.i_operand_a = 32'd3;
        bus.i_operand_b = 32'd3;
        @(negedge clk);
        bus.i_valid = 1'b0;
        wait_idle("divu_after_flush", model_lat(3'b101, 32'd100, 32'd7) - 6);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        issue("mul_reset", 3'b000, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_valid", bus.o_valid, 0);
        chk("midreset_result", bus.o_result, 0);
        chk("midreset_ready", bus.o_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", W'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
